// File: rtl/mult_wb_arbiter.sv
// mult_wb_arbiter: register-file writeback arbiter between the ALU stream and the
// mult5 stage. ALU has priority; displaced mult results wait in an in-order queue
// with write-after-write squash and backpressure toward the mult pipeline.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   mult5_*_i                     mult result: data, dest addr, valid, trace PC
//   alu_*_i                       ALU result: data, dest addr, valid, trace PC
//   mult_stall_o                  queue full; mult pipeline must freeze
//   rf_write_{data,addr,enable}_o registered register-file write port
//   rf_pc_o                       registered PC of the retiring write
module mult_wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mult5_int_write_data_i,
    input  logic [4:0]  mult5_write_addr_i,
    input  logic        mult5_int_write_enable_i,
    input  logic [31:0] mult5_pc_i,
    input  logic [31:0] alu_int_write_data_i,
    input  logic [4:0]  alu_write_addr_i,
    input  logic        alu_int_write_enable_i,
    input  logic [31:0] alu_pc_i,
    output logic        mult_stall_o,
    output logic [31:0] rf_write_data_o,
    output logic [4:0]  rf_write_addr_o,
    output logic        rf_write_enable_o,
    output logic [31:0] rf_pc_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      data_q [DEPTH];
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] rf_data_q, rf_data_d, rf_pc_q, rf_pc_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic        rf_we_q, rf_we_d;

    logic accept, push, pop, squash;

    assign mult_stall_o      = (count_q == CNT_W'(DEPTH));
    assign accept            = mult5_int_write_enable_i && !mult_stall_o;
    assign squash            = alu_int_write_enable_i && (alu_write_addr_i != 5'd0);
    assign rf_write_data_o   = rf_data_q;
    assign rf_write_addr_o   = rf_addr_q;
    assign rf_write_enable_o = rf_we_q;
    assign rf_pc_o           = rf_pc_q;

    // Winner selection: ALU, then queue head, then direct mult bypass.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        rf_data_d = rf_data_q;
        rf_addr_d = rf_addr_q;
        rf_pc_d   = rf_pc_q;
        rf_we_d   = 1'b0;
        if (alu_int_write_enable_i) begin
            rf_data_d = alu_int_write_data_i;
            rf_addr_d = alu_write_addr_i;
            rf_pc_d   = alu_pc_i;
            rf_we_d   = (alu_write_addr_i != 5'd0);
            // A same-cycle mult to the ALU's register is older, hence dead.
            push      = accept && !(squash && (mult5_write_addr_i == alu_write_addr_i));
        end else if (count_q != '0) begin
            pop       = 1'b1;
            rf_data_d = data_q[rd_ptr_q];
            rf_addr_d = addr_q[rd_ptr_q];
            rf_pc_d   = pc_q[rd_ptr_q];
            rf_we_d   = valid_q[rd_ptr_q] && (addr_q[rd_ptr_q] != 5'd0);
            push      = accept;
        end else if (accept) begin
            rf_data_d = mult5_int_write_data_i;
            rf_addr_d = mult5_write_addr_i;
            rf_pc_d   = mult5_pc_i;
            rf_we_d   = (mult5_write_addr_i != 5'd0);
        end
    end

    // Queue bookkeeping: squashed slots keep their place but lose their valid bit.
    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            if (squash && (addr_q[i] == alu_write_addr_i)) valid_d[i] = 1'b0;
            if (push && (wr_ptr_q == PTR_W'(i)))           valid_d[i] = 1'b1;
        end
    end

    // Control and output state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rf_data_q <= '0;
            rf_addr_q <= '0;
            rf_pc_q   <= '0;
            rf_we_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rf_data_q <= rf_data_d;
            rf_addr_q <= rf_addr_d;
            rf_pc_q   <= rf_pc_d;
            rf_we_q   <= rf_we_d;
        end
    end

    // Queue payload storage; meaningless unless the slot is occupied.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= mult5_int_write_data_i;
            addr_q[wr_ptr_q] <= mult5_write_addr_i;
            pc_q[wr_ptr_q]   <= mult5_pc_i;
        end
    end

endmodule

// File: tb/tb_mult_wb_arbiter.sv
module tb_mult_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_data, m_pc, a_data, a_pc;
    logic [4:0]  m_addr, a_addr;
    logic        m_we, a_we;
    logic        stall;
    logic [31:0] rf_data, rf_pc;
    logic [4:0]  rf_addr;
    logic        rf_we;

    always #5 clk = ~clk;

    mult_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .mult5_int_write_data_i   (m_data),
        .mult5_write_addr_i       (m_addr),
        .mult5_int_write_enable_i (m_we),
        .mult5_pc_i               (m_pc),
        .alu_int_write_data_i     (a_data),
        .alu_write_addr_i         (a_addr),
        .alu_int_write_enable_i   (a_we),
        .alu_pc_i                 (a_pc),
        .mult_stall_o             (stall),
        .rf_write_data_o          (rf_data),
        .rf_write_addr_o          (rf_addr),
        .rf_write_enable_o        (rf_we),
        .rf_pc_o                  (rf_pc)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic        vld;
    } ent_t;

    ent_t        q[$];
    logic [31:0] e_data, e_pc;
    logic [4:0]  e_addr;
    logic        e_we;
    logic [31:0] regs [32];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic win(input logic [31:0] d, input logic [4:0] a, input logic [31:0] p, input bit v);
        e_data = d;
        e_addr = a;
        e_pc   = p;
        e_we   = v && (a != 5'd0);
        if (e_we) regs[a] = d;
    endtask

    // Reference: queue of pending mult results, priority rules applied directly.
    task automatic model_step();
        bit   acc;
        ent_t m;
        ent_t h;
        acc = m_we && (q.size() != DEPTH);
        m   = '{m_data, m_addr, m_pc, 1'b1};
        if (a_we) begin
            win(a_data, a_addr, a_pc, 1'b1);
            if (a_addr != 5'd0) begin
                foreach (q[i]) if (q[i].addr == a_addr) q[i].vld = 1'b0;
                if (m_addr == a_addr) acc = 1'b0;
            end
            if (acc) q.push_back(m);
        end else if (q.size() > 0) begin
            h = q.pop_front();
            win(h.data, h.addr, h.pc, h.vld);
            if (acc) q.push_back(m);
        end else if (acc) begin
            win(m_data, m_addr, m_pc, 1'b1);
        end else begin
            e_we = 1'b0;
        end
    endtask

    // One clock: drive at negedge, check stall, step model at posedge, check outputs.
    task automatic cyc(input bit aw, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mw, input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        a_we = aw; a_addr = aa; a_data = ad; a_pc = 32'h1000 + ad;
        m_we = mw; m_addr = ma; m_data = md; m_pc = 32'h2000 + md;
        #1 chk("stall", 32'(stall), 32'(q.size() == DEPTH));
        @(posedge clk);
        model_step();
        #1;
        chk("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            chk("rf_data", rf_data, e_data);
            chk("rf_addr", 32'(rf_addr), 32'(e_addr));
            chk("rf_pc", rf_pc, e_pc);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        foreach (regs[i]) regs[i] = 32'd0;
        rst = 1'b1;
        a_we = 0; a_addr = 0; a_data = 0; a_pc = 0;
        m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
        e_we = 0; e_data = 0; e_addr = 0; e_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", 32'(rf_we), 32'd0);
        chk("reset_data", rf_data, 32'd0);
        chk("reset_addr", 32'(rf_addr), 32'd0);
        chk("reset_pc", rf_pc, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Mult alone bypasses straight to the write port.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        chk("t1_we", 32'(rf_we), 32'd1);
        chk("t1_addr", 32'(rf_addr), 32'd5);
        chk("t1_data", rf_data, 32'h1234);

        // Conflict: ALU first, mult one cycle later.
        cyc(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        chk("t2_alu_addr", 32'(rf_addr), 32'd3);
        chk("t2_alu_data", rf_data, 32'hA);
        idle();
        chk("t2_mult_addr", 32'(rf_addr), 32'd7);
        chk("t2_mult_data", rf_data, 32'hB);

        // Fill to DEPTH, then drain in push order.
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(10 + i), 32'h200 + i);
        @(negedge clk); #1 chk("t3_stall_full", 32'(stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t3_drain_addr", 32'(rf_addr), 32'(10 + i));
            chk("t3_drain_data", rf_data, 32'h200 + i);
        end
        @(negedge clk); #1 chk("t3_stall_clear", 32'(stall), 32'd0);

        // WAW squash of a queued entry.
        cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
        cyc(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
        chk("t4_alu_data", rf_data, 32'h55);
        idle();
        chk("t4_stale_we", 32'(rf_we), 32'd0);
        chk("t4_reg9", regs[9], 32'h55);

        // Writes to x0 never strobe.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        chk("t5_x0_we", 32'(rf_we), 32'd0);

        // Reset with three queued entries.
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd4, 32'h300 + i, 1'b1, 5'(20 + i), 32'h400 + i);
        @(negedge clk);
        a_we = 0; m_we = 0;
        rst = 1'b1;
        #1;
        chk("t6_we", 32'(rf_we), 32'd0);
        chk("t6_data", rf_data, 32'd0);
        chk("t6_addr", 32'(rf_addr), 32'd0);
        chk("t6_stall", 32'(stall), 32'd0);
        q.delete();
        e_we = 1'b0;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t6_nothing_retires", 32'(rf_we), 32'd0);
        end

        // Randomized traffic with narrow address range to provoke squashes.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
